// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - UART receiver with start validation, framing/overrun detection and a one-word output buffer.
// Optional even-parity stage and parity_err port are built when UART_RX_PARITY_EN is defined.
module uart_rx_framed #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BITN_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BITN_W-1:0] LAST_BIT = BITN_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t                  state, state_n;
  logic [1:0]              sync;
  logic                    rx_s;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [BITN_W-1:0]       bitn, bitn_n;
  logic [DATA_WIDTH-1:0]   shift, shift_n;
  logic                    frame_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                    par, par_n;
  logic                    par_bad;
`endif

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    shift_n  = shift;
    frame_ok = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n    = par;
    par_bad  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bitn_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          // LSB-first: after DATA_WIDTH shifts the first bit sits in bit 0
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_WIDTH-1:1]};
          bitn_n  = bitn + 1'b1;
          if (bitn == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par}) par_bad = 1'b1;
            else frame_ok = 1'b1;
`else
            frame_ok = 1'b1;
`endif
          end else begin
            stop_bad = 1'b1;
            state_n  = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      sync  <= {sync[0], rx};
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shift <= shift_n;
`ifdef UART_RX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // Holding register: a same-cycle consume frees the slot for the new word
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= stop_bad;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= par_bad;
`endif
      if (frame_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed (8 data bits, 16 clocks per bit).
module tb_uart_rx_framed;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 155 + N;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         perr_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got[$];

  uart_rx_framed #(.DATA_WIDTH(8), .CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int bits);
    rx = 1'b1;
    repeat (bits * N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    int t0, f0, o0;
    logic [7:0] d;
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    idle_bits(1);

    // single frame, latency from first low capture to rx_valid
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    check("lat", rise_cyc - t0, LAT);
    check("a5_cnt", got.size(), 1);
    check("a5_data", got[0], 8'hA5);
    check("a5_noerr", ferr_cnt + ovr_cnt, 0);

    // 3-cycle low glitch
    got.delete();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy", busy, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_idle", busy, 1'b0);
    check("glitch_valid", got.size(), 0);
    check("glitch_ferr", ferr_cnt, 0);

    // bad stop bit followed by a long break
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (100 * N) @(posedge clk);
    #1;
    check("brk_busy", busy, 1'b1);
    check("brk_ferr", ferr_cnt - f0, 1);
    check("brk_valid", rx_valid, 1'b0);
    idle_bits(2);
    check("brk_idle", busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check("brk_cnt", got.size(), 1);
    check("brk_data", got[0], 8'h5A);

    // overrun with consumer stalled
    got.delete();
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1);
    idle_bits(2);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_clear", rx_valid, 1'b0);
    check("ovr_taken", got.size() == 1 && got[0] == 8'h11, 1'b1);

    // back-to-back frames, no idle gap
    got.delete();
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    idle_bits(2);
    check("b2b_cnt", got.size(), 3);
    check("b2b_0", got[0], 8'h01);
    check("b2b_1", got[1], 8'hFF);
    check("b2b_2", got[2], 8'h80);

    // reset during data bit 4
    got.delete();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (N / 2) @(posedge clk);
    #1;
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", rx_valid, 1'b0);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_ferr", frame_err, 1'b0);
    check("mrst_ovr", overrun, 1'b0);
    idle_bits(2);
    check("mrst_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'hC3, 1'b1);
    idle_bits(2);
    check("c3_cnt", got.size(), 1);
    check("c3_data", got[0], 8'hC3);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    got.delete();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    idle_bits(2);
    check("par_bad_pulse", perr_cnt, 1);
    check("par_bad_nodata", got.size(), 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle_bits(2);
    check("par_ok_pulse", perr_cnt, 1);
    check("par_ok_data", got.size() == 1 && got[0] == 8'h07, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
